// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stalls, branch flushes,
// data-memory wait freezes with deferred branches, and saturating perf counters.
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int FLUSH_EXTRA = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs2,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  localparam logic [3:0] FE      = 4'(FLUSH_EXTRA);
  localparam state_t     BR_DEST = (FLUSH_EXTRA > 0) ? FLUSH : RUN;

  state_t     state_reg, state_next;
  logic [3:0] fcnt_reg, fcnt_next;
  logic       br_pend_reg, br_pend_next;
  logic       load_use;
  logic       branch;

  assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));
  assign branch   = branch_taken || br_pend_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= RUN;
      fcnt_reg    <= 4'd0;
      br_pend_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      fcnt_reg    <= fcnt_next;
      br_pend_reg <= br_pend_next;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_hold    = 1'b0;
    state_next   = state_reg;
    fcnt_next    = fcnt_reg;
    br_pend_next = br_pend_reg;

    if (dmem_busy) begin
      // Freeze everything; a branch resolving now is replayed once memory is ready.
      pipe_hold   = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if (branch_taken) br_pend_next = 1'b1;
      if (state_reg != FLUSH) state_next = MEM_WAIT;
    end else if (branch) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      br_pend_next = 1'b0;
      fcnt_next    = FE;
      state_next   = BR_DEST;
    end else if (state_reg == FLUSH) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      fcnt_next   = fcnt_reg - 4'd1;
      if (fcnt_reg == 4'd1) state_next = RUN;
    end else begin
      if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
      state_next = RUN;
    end
  end

  logic [1:0] cnt_inc;
  assign cnt_inc = {ex_mem_flush, ~pc_write};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          cnt_reg <= '0;
        else if (cnt_clr)
          cnt_reg <= '0;
        else if (cnt_inc[gi] && (cnt_reg != '1))
          cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  endgenerate

  assign stall_cycles = g_cnt[0].cnt_reg;
  assign flush_events = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (4-bit counters with two extra flush
// cycles, and default parameters) compared against a cycle-level reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd;
  logic        if_id_uses_rs2, id_ex_memread, branch_taken, dmem_busy, cnt_clr;

  logic        pc_write_a, if_id_write_a, if_id_flush_a, id_ex_flush_a, ex_mem_flush_a, pipe_hold_a;
  logic [3:0]  stall_a, flush_a;
  logic        pc_write_b, if_id_write_b, if_id_flush_b, id_ex_flush_b, ex_mem_flush_b, pipe_hold_b;
  logic [31:0] stall_b, flush_b;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(4), .FLUSH_EXTRA(2)) dut_a (
    .clk(clk), .reset(reset),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy), .cnt_clr(cnt_clr),
    .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a),
    .id_ex_flush(id_ex_flush_a), .ex_mem_flush(ex_mem_flush_a), .pipe_hold(pipe_hold_a),
    .stall_cycles(stall_a), .flush_events(flush_a)
  );

  hazard_ctrl dut_b (
    .clk(clk), .reset(reset),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy), .cnt_clr(cnt_clr),
    .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b),
    .id_ex_flush(id_ex_flush_b), .ex_mem_flush(ex_mem_flush_b), .pipe_hold(pipe_hold_b),
    .stall_cycles(stall_b), .flush_events(flush_b)
  );

  // Reference model: flush cycles still owed, pending branch flag, counters.
  int              m_fe [2]   = '{2, 0};
  longint unsigned m_max [2]  = '{64'd15, 64'hFFFF_FFFF};
  int              m_left [2];
  bit              m_pend [2];
  longint unsigned m_sc [2];
  longint unsigned m_fc [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold}
  function automatic logic [5:0] model_ctl(int k);
    bit hz;
    hz = id_ex_memread && (id_ex_rd != 0) &&
         (id_ex_rd == if_id_rs1 || (if_id_uses_rs2 && id_ex_rd == if_id_rs2));
    if (dmem_busy)                   return 6'b000001;
    if (branch_taken || m_pend[k])   return 6'b111110;
    if (m_left[k] > 0)               return 6'b111100;
    if (hz)                          return 6'b000100;
    return 6'b110000;
  endfunction

  task automatic check_all();
    logic [5:0] obs [2];
    obs[0] = {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_flush_a, ex_mem_flush_a, pipe_hold_a};
    obs[1] = {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_flush_b, ex_mem_flush_b, pipe_hold_b};
    for (int k = 0; k < 2; k++)
      chk($sformatf("ctl%0d", k), 32'(obs[k]), 32'(model_ctl(k)));
    chk("stall0", 32'(stall_a), 32'(m_sc[0]));
    chk("flush0", 32'(flush_a), 32'(m_fc[0]));
    chk("stall1", stall_b, 32'(m_sc[1]));
    chk("flush1", flush_b, 32'(m_fc[1]));
  endtask

  task automatic model_step();
    logic [5:0] e;
    for (int k = 0; k < 2; k++) begin
      e = model_ctl(k);
      if (cnt_clr) begin
        m_sc[k] = 0;
        m_fc[k] = 0;
      end else begin
        if (!e[5] && m_sc[k] < m_max[k]) m_sc[k]++;
        if (e[1] && m_fc[k] < m_max[k])  m_fc[k]++;
      end
      if (dmem_busy) begin
        if (branch_taken) m_pend[k] = 1'b1;
      end else if (branch_taken || m_pend[k]) begin
        m_pend[k] = 1'b0;
        m_left[k] = m_fe[k];
      end else if (m_left[k] > 0) begin
        m_left[k]--;
      end
    end
  endtask

  task automatic run_cycle(input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                           input logic mr, input logic [4:0] rd, input logic bt,
                           input logic busy, input logic clr);
    if_id_rs1 = r1; if_id_rs2 = r2; if_id_uses_rs2 = u2;
    id_ex_memread = mr; id_ex_rd = rd;
    branch_taken = bt; dmem_busy = busy; cnt_clr = clr;
    #1;
    check_all();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; checked 1ns later, before any clock edge.
  task automatic do_reset();
    reset = 1'b0;
    if_id_rs1 = 0; if_id_rs2 = 0; if_id_uses_rs2 = 0; id_ex_memread = 0; id_ex_rd = 0;
    branch_taken = 0; dmem_busy = 0; cnt_clr = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_pend[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int busy_left;
    if_id_rs1 = 0; if_id_rs2 = 0; if_id_uses_rs2 = 0; id_ex_memread = 0; id_ex_rd = 0;
    branch_taken = 0; dmem_busy = 0; cnt_clr = 0;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    idle(2);

    // Load-use on rs2, then the same with rd=0 (no hazard)
    run_cycle(5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("lu_stall_cnt", 32'(stall_a), 32'd1);
    run_cycle(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_rd0_cnt", 32'(stall_a), 32'd1);
    idle(1);

    // Branch pulse: 3 flush cycles on dut_a, 1 on dut_b
    run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("br_events", 32'(flush_a), 32'd1);
    idle(3);

    // Memory wait of 4 cycles with a branch in the 2nd
    run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("wait_stall_cnt", stall_b, 32'd5);
    run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("deferred_br_events", flush_b, 32'd2);
    idle(3);

    // Load-use and branch together: branch wins, no stall counted
    run_cycle(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("lu_br_stall_cnt", 32'(stall_a), 32'd5);
    idle(3);

    // Saturation of the 4-bit counter, then clear together with a stall
    for (int i = 0; i < 20; i++) run_cycle(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("stall_sat", 32'(stall_a), 32'd15);
    chk("stall_nosat", stall_b, 32'd25);
    run_cycle(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    chk("clr_a", 32'(stall_a), 32'd0);
    chk("clr_b", stall_b, 32'd0);

    // Reset in the middle of a wait holding a pending branch
    run_cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    do_reset();
    idle(2);

    // Randomized traffic
    busy_left = 0;
    for (int i = 0; i < 3000; i++) begin
      logic busy;
      if (busy_left > 0) begin
        busy = 1'b1;
        busy_left--;
      end else if ($urandom_range(0, 7) == 0) begin
        busy = 1'b1;
        busy_left = $urandom_range(0, 4);
      end else begin
        busy = 1'b0;
      end
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        busy_left = 0;
      end else begin
        run_cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 9) == 0), busy, 1'($urandom_range(0, 79) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RISC-V core. It generates the write-enable, hold and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers: load-use stalls, taken-branch flushes and data-memory wait freezes. It keeps a branch that resolves during a memory wait pending until the wait ends. It also maintains saturating stall and flush performance counters. It sits beside the pipeline registers and drives the `flush` input of the ID/EX register.

## Interface
- `CNT_W`, 32: width of performance counters.
- `FLUSH_EXTRA`, 0: extra cycles (0–15) that IF/ID and ID/EX flush stay asserted after a taken branch.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_id_rs1` in 5: rs1 of the instruction in ID.
- `if_id_rs2` in 5: rs2 of the instruction in ID.
- `if_id_uses_rs2` in 1: the ID instruction reads rs2 (R/S/B type).
- `id_ex_memread` in 1: MemRead of the instruction in EX.
- `id_ex_rd` in 5: rd of the instruction in EX.
- `branch_taken` in 1: taken branch resolved in MEM (one-cycle pulse).
- `dmem_busy` in 1: data memory not ready (level).
- `cnt_clr` in 1: synchronous clear of both counters.
- `pc_write` out 1: PC update enable.
- `if_id_write` out 1: IF/ID load enable.
- `if_id_flush` out 1: zero the IF/ID instruction.
- `id_ex_flush` out 1: zero the ID/EX control fields.
- `ex_mem_flush` out 1: zero the EX/MEM control fields.
- `pipe_hold` out 1: freeze all pipeline registers.
- `stall_cycles` out CNT_W: number of cycles in which `pc_write` was 0.
- `flush_events` out CNT_W: number of branch flushes applied.

## Operation
- **Registered state:**
  - FSM states: RUN, MEM_WAIT, FLUSH.
  - 4-bit flush down-counter `fcnt`.
  - `br_pend` flag.
  - Two counters.
- **Control outputs:** combinational from the current state and inputs. Priority in every cycle: `dmem_busy` > branch (`branch_taken` or `br_pend`) > load-use.
- **Load-use hazard:** `id_ex_memread & (id_ex_rd != 0) & ((id_ex_rd == if_id_rs1) | (if_id_uses_rs2 & id_ex_rd == if_id_rs2))`.
- **RUN state:**
  - `dmem_busy`=1: `pipe_hold`=1, `pc_write`=0, `if_id_write`=0, no flushes. Next state is MEM_WAIT. If `branch_taken` is also 1, set `br_pend`.
  - Branch (`branch_taken` or `br_pend`): `if_id_flush`, `id_ex_flush` and `ex_mem_flush` = 1; `pc_write`=1 (target load); `br_pend` clears. Next state is FLUSH with `fcnt`=FLUSH_EXTRA if FLUSH_EXTRA>0, otherwise RUN.
  - Load-use: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1. Stay in RUN.
  - Otherwise: `pc_write`=1, `if_id_write`=1, all flushes 0.
- **MEM_WAIT state:**
  - `dmem_busy`=1: `pipe_hold`=1, `pc_write`=0, `if_id_write`=0. A `branch_taken` seen here sets `br_pend`.
  - `dmem_busy`=0: behave exactly as RUN (branch, load-use or normal) and leave MEM_WAIT per the RUN rules.
- **FLUSH state:**
  - `if_id_flush`=1, `id_ex_flush`=1, `pc_write`=1, `if_id_write`=1.
  - `fcnt` decrements each cycle; at `fcnt`==1, return to RUN.
  - `dmem_busy`=1 overrides the flush outputs with hold outputs and freezes `fcnt`.
  - A new `branch_taken` reloads `fcnt`=FLUSH_EXTRA, asserts `ex_mem_flush` that cycle, and counts as a flush event.
- **Counters:**
  - `stall_cycles` increments on every cycle with `pc_write`=0.
  - `flush_events` increments on every cycle in which a branch flush is applied (`ex_mem_flush`=1).
  - Both saturate at 2^CNT_W−1.
  - `cnt_clr` takes priority over increment: the counter becomes 0 that edge, and the increment for that cycle is lost.

## Timing
- **Reset** (`reset`=0, asynchronous): state=RUN, `fcnt`=0, `br_pend`=0, both counters 0.
- **Outputs after reset with idle inputs:** `pc_write`=1, `if_id_write`=1, all flushes 0, `pipe_hold`=0.
- **Control latency:** zero cycles. Outputs respond in the same cycle as the inputs; the pipeline registers act on them at the next rising edge.
- **State/counter latency:** state and counters update one edge after the qualifying cycle.
- **Load-use bubble:** exactly 1 cycle. The hazard condition clears naturally once the bubble reaches EX.
- **Branch penalty:** 1 + FLUSH_EXTRA cycles of flush. A branch deferred by a memory wait is applied on the first cycle with `dmem_busy`=0.
- **Reset mid-operation:** a reset during MEM_WAIT or FLUSH discards `br_pend` and `fcnt`. The counters clear.

## Test plan
- Reset, then drive idle inputs → `pc_write`=1, `if_id_write`=1, flushes 0, counters 0.
- `id_ex_memread`=1, `id_ex_rd`=5, `if_id_rs2`=5, `if_id_uses_rs2`=1 for one cycle → `pc_write`=0, `id_ex_flush`=1 that cycle; `stall_cycles`=1 afterwards. Repeating with `id_ex_rd`=0 gives no stall.
- `branch_taken` pulse with FLUSH_EXTRA=2 → three flush cycles, `ex_mem_flush` in the first cycle only; `flush_events`=1.
- `dmem_busy` high for 4 cycles with `branch_taken` pulsed in the 2nd → `pipe_hold`=1 for 4 cycles; the branch flush fires on the 5th cycle; `stall_cycles`=4.
- Load-use hazard and `branch_taken` in the same cycle → only the branch flush is applied (`pc_write`=1); `stall_cycles` is unchanged.
- CNT_W=4: force 20 stall cycles → `stall_cycles` saturates at 15. `cnt_clr`=1 together with a stall → 0 next cycle.
